// File: rtl/vram_port_arbiter.sv
// Shares one single-port VRAM BRAM between pixel fetch (priority) and the bus slave.
// Defining VRAM_ARB_STATS_EN enables the stall_cnt wait-cycle statistic.
module vram_port_arbiter #(
    parameter int DEPTH      = 601,
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_req,
    input  logic [ADDR_W-1:0] pix_addr,
    output logic              pix_gnt,
    output logic              pix_rvalid,
    output logic [31:0]       pix_rdata,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [3:0]        bus_be,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic              bus_ack,
    output logic [31:0]       bus_rdata,
    output logic              bus_err,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [3:0]        bram_we,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata,
    output logic [15:0]       stall_cnt
);

    localparam int WAIT_W = $clog2(STARVE_LIM + 1);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIM);
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

    state_t            state, state_nxt;
    logic [1:0]        lat_cnt, lat_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [RD_LAT-1:0] tok;
    logic [31:0]       rdata_q;
    logic              ack_q, ack_nxt;
    logic              err_q, err_nxt;
    logic              ack_d;
    logic              in_range, bus_idle, force_bus;
    logic              bus_issue, bus_wait, rd_done, clr_rdata;

    assign in_range = {{(32-ADDR_W){1'b0}}, bus_addr} < DEPTH_U;

    // A held bus_req is ignored for one cycle after its ack.
    assign bus_idle  = (state == IDLE) && !ack_d;
    assign force_bus = (wait_cnt == WAIT_MAX) && bus_req && bus_idle;
    assign rd_done   = (state == RD_WAIT) && (lat_cnt == 2'd0);

    always_comb begin
        pix_gnt    = 1'b0;
        bus_issue  = 1'b0;
        bram_addr  = '0;
        bram_we    = '0;
        bram_wdata = '0;
        if (force_bus) begin
            bus_issue = 1'b1;
        end else if (pix_req) begin
            pix_gnt   = 1'b1;
            bram_addr = pix_addr;
        end else if (bus_req && bus_idle) begin
            bus_issue = 1'b1;
        end
        if (bus_issue) begin
            bram_addr = bus_addr;
            if (bus_we && in_range) begin
                bram_we    = bus_be;
                bram_wdata = bus_wdata;
            end
        end
    end

    // Only cycles spent genuinely waiting for a slot count as waits.
    assign bus_wait = bus_req && bus_idle && !bus_issue;

    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        ack_nxt     = 1'b0;
        err_nxt     = 1'b0;
        clr_rdata   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus_issue) begin
                    if (!in_range) begin
                        state_nxt = ACK;
                        ack_nxt   = 1'b1;
                        err_nxt   = 1'b1;
                        clr_rdata = !bus_we;
                    end else if (bus_we) begin
                        state_nxt = ACK;
                        ack_nxt   = 1'b1;
                    end else begin
                        state_nxt   = RD_WAIT;
                        lat_cnt_nxt = LAT_LOAD;
                        ack_nxt     = (LAT_LOAD == 2'd0);
                    end
                end
            end
            RD_WAIT: begin
                if (lat_cnt == 2'd0) begin
                    state_nxt = IDLE;
                end else begin
                    lat_cnt_nxt = lat_cnt - 2'd1;
                    ack_nxt     = (lat_cnt == 2'd1);
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            ack_d    <= 1'b0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            tok      <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
            ack_q   <= ack_nxt;
            err_q   <= err_nxt;
            ack_d   <= ack_q;
            if (bus_issue) begin
                wait_cnt <= '0;
            end else if (bus_wait && wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (rd_done) begin
                rdata_q <= bram_rdata;
            end else if (clr_rdata) begin
                rdata_q <= '0;
            end
            tok[0] <= pix_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                tok[i] <= tok[i-1];
            end
        end
    end

    assign bus_ack    = ack_q;
    assign bus_err    = err_q;
    assign bus_rdata  = rd_done ? bram_rdata : rdata_q;
    assign pix_rvalid = tok[RD_LAT-1];
    assign pix_rdata  = pix_rvalid ? bram_rdata : 32'd0;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((bus_wait || (force_bus && pix_req)) && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
